pipe_elastic_stage: RTL and testbench

//  Parametrised elastic inter-stage register: successor to the fixed stall/flush stage latches.

---
 rtl/pipe_elastic_stage_pkg.sv | 13 +
 rtl/pipe_elastic_stage_if.sv | 11 +
 rtl/pipe_elastic_stage.sv | 98 +++++++++
 tb/tb_pipe_elastic_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_elastic_stage_pkg.sv
// Shared definitions for the elastic inter-stage register.
package pipe_elastic_stage_pkg;

   localparam int unsigned PIPE_STALL_CNT_W = 32;

   // Occupancy state; bit0 = main slot valid, bit1 = skid slot valid
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } pipe_state_e;

endpackage

// File: rtl/pipe_elastic_stage_if.sv
// One valid/ready payload channel; master drives valid/data, slave drives ready.
interface pipe_elastic_stage_if #(
   parameter int unsigned WIDTH = 64
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input  ready);
   modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline register: 2-entry skid buffer with registered in_ready,
// plus a saturating backpressure-cycle counter.
module pipe_elastic_stage
   import pipe_elastic_stage_pkg::*;
#(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned CNT_W    = PIPE_STALL_CNT_W,
   parameter bit          ZERO_PAY = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   pipe_elastic_stage_if.slave  in_bus,
   pipe_elastic_stage_if.master out_bus,
   output logic [CNT_W-1:0]     stall_cnt,
   input  logic                 cnt_clr
);

   pipe_state_e      state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             push_c, pop_c;
   logic [WIDTH-1:0] vacated_c;

   // Outputs come straight from state flops, so no combinational path crosses the stage
   assign out_bus.valid = state_q[0];
   assign out_bus.data  = main_q;
   assign in_bus.ready  = ~state_q[1];

   assign push_c    = in_bus.valid & in_bus.ready;
   assign pop_c     = out_bus.valid & out_bus.ready;
   assign vacated_c = ZERO_PAY ? '0 : main_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         if (ZERO_PAY) begin
            main_d = '0;
            skid_d = '0;
         end
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (push_c) begin
                  state_d = ST_ONE;
                  main_d  = in_bus.data;
               end
            end
            ST_ONE: begin
               if (push_c && pop_c) begin
                  main_d = in_bus.data;
               end else if (push_c) begin
                  state_d = ST_FULL;
                  skid_d  = in_bus.data;
               end else if (pop_c) begin
                  state_d = ST_EMPTY;
                  main_d  = vacated_c;
               end
            end
            ST_FULL: begin
               if (pop_c) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
                  if (ZERO_PAY) skid_d = '0;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Saturating stall counter; clear wins over increment, flush leaves it alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
      end else if (out_bus.valid && !out_bus.ready && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed and randomised checks of pipe_elastic_stage against a queue model.
module tb_pipe_elastic_stage;
   import pipe_elastic_stage_pkg::*;

   localparam int unsigned W  = 16;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          cnt_clr;
   logic [CW-1:0] stall_cnt;

   pipe_elastic_stage_if #(.WIDTH(W)) in_bus ();
   pipe_elastic_stage_if #(.WIDTH(W)) out_bus ();

   pipe_elastic_stage #(.WIDTH(W), .CNT_W(CW), .ZERO_PAY(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_bus    (in_bus),
      .out_bus   (out_bus),
      .stall_cnt (stall_cnt),
      .cnt_clr   (cnt_clr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_io(input string tag, input logic ov, input logic ir, input logic [W-1:0] od);
      chk({tag, "_ov"}, 32'(out_bus.valid), 32'(ov));
      chk({tag, "_ir"}, 32'(in_bus.ready), 32'(ir));
      chk({tag, "_od"}, 32'(out_bus.data), 32'(od));
   endtask

   initial begin
      rst_n          = 1'b1;
      flush          = 1'b0;
      cnt_clr        = 1'b0;
      in_bus.valid   = 1'b0;
      in_bus.data    = '0;
      out_bus.ready  = 1'b0;
      #1 rst_n = 1'b0;
      #11;
      chk_io("reset", 1'b0, 1'b1, 16'h0);
      chk("reset_cnt", 32'(stall_cnt), 32'h0);
      rst_n = 1'b1;
      tick();

      // 1: streaming at full rate
      in_bus.valid  = 1'b1;
      out_bus.ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_bus.data = 16'(i);
         tick();
         chk_io("stream", 1'b1, 1'b1, 16'(i));
      end
      in_bus.valid = 1'b0;
      tick();
      chk_io("stream_end", 1'b0, 1'b1, 16'h0);
      chk("stream_cnt", 32'(stall_cnt), 32'h0);

      // 2: fill under backpressure, then drain in order
      out_bus.ready = 1'b0;
      in_bus.valid  = 1'b1;
      in_bus.data   = 16'hA0A0;
      tick();
      chk_io("fill_a", 1'b1, 1'b1, 16'hA0A0);
      in_bus.data = 16'hB0B0;
      tick();
      chk_io("fill_b", 1'b1, 1'b0, 16'hA0A0);
      in_bus.valid = 1'b0;
      tick();
      chk("full_cnt", 32'(stall_cnt), 32'h2);
      out_bus.ready = 1'b1;
      tick();
      chk_io("drain_b", 1'b1, 1'b1, 16'hB0B0);
      tick();
      chk_io("drain_end", 1'b0, 1'b1, 16'h0);
      chk("drain_cnt", 32'(stall_cnt), 32'h2);

      // 3: flush while full drops held entries and the concurrent push
      out_bus.ready = 1'b0;
      in_bus.valid  = 1'b1;
      in_bus.data   = 16'hD0D0;
      tick();
      in_bus.data = 16'hE0E0;
      tick();
      chk_io("pre_flush", 1'b1, 1'b0, 16'hD0D0);
      in_bus.data = 16'hC0C0;
      flush       = 1'b1;
      tick();
      chk_io("flush", 1'b0, 1'b1, 16'h0);
      flush         = 1'b0;
      in_bus.valid  = 1'b0;
      out_bus.ready = 1'b1;
      tick();
      chk_io("post_flush", 1'b0, 1'b1, 16'h0);

      // 4: counter saturation and clear-over-increment
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clr", 32'(stall_cnt), 32'h0);
      out_bus.ready = 1'b0;
      in_bus.valid  = 1'b1;
      in_bus.data   = 16'h1234;
      tick();
      in_bus.valid = 1'b0;
      for (int i = 0; i < 19; i++) tick();
      chk("sat", 32'(stall_cnt), 32'hF);
      cnt_clr = 1'b1;
      tick();
      chk("clr_stall", 32'(stall_cnt), 32'h0);
      cnt_clr = 1'b0;
      tick();
      chk("restart", 32'(stall_cnt), 32'h1);
      out_bus.ready = 1'b1;
      tick();
      chk_io("sat_drain", 1'b0, 1'b1, 16'h0);

      // 5: async reset between edges while full
      out_bus.ready = 1'b0;
      in_bus.valid  = 1'b1;
      in_bus.data   = 16'h1111;
      tick();
      in_bus.data = 16'h2222;
      tick();
      in_bus.valid = 1'b0;
      chk_io("pre_rst", 1'b1, 1'b0, 16'h1111);
      #2 rst_n = 1'b0;
      #1;
      chk_io("async_rst", 1'b0, 1'b1, 16'h0);
      chk("async_rst_cnt", 32'(stall_cnt), 32'h0);
      #1 rst_n = 1'b1;
      tick();
      chk_io("rst_release", 1'b0, 1'b1, 16'h0);
      out_bus.ready = 1'b1;
      in_bus.valid  = 1'b1;
      in_bus.data   = 16'h5555;
      tick();
      chk_io("post_rst", 1'b1, 1'b1, 16'h5555);
      in_bus.valid = 1'b0;
      tick();

      // 6: random traffic against a FIFO model of depth 2
      q.delete();
      for (int c = 0; c < 10000; c++) begin
         logic iv, ordy, exp_ir;
         iv     = 1'($urandom_range(0, 1));
         ordy   = 1'($urandom_range(0, 3) != 0);
         exp_ir = (q.size() < 2);
         in_bus.valid  = iv;
         out_bus.ready = ordy;
         if (iv && exp_ir) in_bus.data = 16'($urandom);
         chk("rnd_ir", 32'(in_bus.ready), 32'(exp_ir));
         chk("rnd_ov", 32'(out_bus.valid), 32'(q.size() != 0));
         if (q.size() != 0) chk("rnd_od", 32'(out_bus.data), 32'(q[0]));
         chk("rnd_skid_main", 32'(!in_bus.ready && !out_bus.valid), 32'h0);
         if (iv && exp_ir) q.push_back(in_bus.data);
         if (q.size() != 0 && ordy && !(iv && exp_ir && q.size() == 1)) void'(q.pop_front());
         else if (q.size() == 2 && ordy && iv && exp_ir) void'(q.pop_front());
         tick();
      end
      in_bus.valid  = 1'b0;
      out_bus.ready = 1'b1;
      for (int c = 0; c < 4 && q.size() != 0; c++) begin
         chk("rnd_drain_od", 32'(out_bus.data), 32'(q[0]));
         void'(q.pop_front());
         tick();
      end
      chk("rnd_final_ov", 32'(out_bus.valid), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
